dii_channel_arb: RTL

- Parametrised N-input to 1-output DII packet arbiter with a registered, full-throughput output stage.
- Merges N debug-interconnect flit streams (data/last/valid/ready) onto one link.
- Round-robin arbitration at packet granularity: a packet is never interleaved with another.
- Used wherever several debug modules share one upstream DII port; N=1 degenerates to a 2-entry pipeline slice.

---
 rtl/dii_channel_arb.sv | 97 +++++++++
 1 files changed

// File: rtl/dii_channel_arb.sv
// dii_channel_arb: N:1 round-robin DII packet arbiter, packet-atomic, with a
// registered 2-entry skid buffer driving out_*.
module dii_channel_arb #(
    parameter int N = 2,
    parameter int WIDTH = 16,
    localparam int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_last,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic [CW-1:0]        cur_chan
);
    typedef enum logic {IDLE, LOCKED} state_t;
    localparam logic [CW:0] NW = (CW+1)'(N);
    state_t state;
    logic [CW-1:0] rr_ptr, lock, grant, nxt;
    logic [CW:0] gsum, nsum;
    logic [N-1:0] rot;
    logic [WIDTH-1:0] chan_data [N];
    logic [WIDTH-1:0] sk_data, push_data;
    logic any, space, push, push_last, drain, sk_valid, sk_last;

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign chan_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    // Rotate requests so bit 0 is rr_ptr; the lowest set bit wins.
    always_comb begin
        rot = N'({in_valid, in_valid} >> rr_ptr);
        grant = rr_ptr;
        gsum = '0;
        any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                gsum = {1'b0, rr_ptr} + (CW+1)'(k);
                grant = (gsum >= NW) ? CW'(gsum - NW) : CW'(gsum);
                any = 1'b1;
            end
        end
    end

    assign busy      = (state == LOCKED);
    assign cur_chan  = busy ? lock : grant;
    assign nsum      = {1'b0, cur_chan} + (CW+1)'(1);
    assign nxt       = (nsum >= NW) ? CW'(nsum - NW) : CW'(nsum);
    // sk_valid implies out_valid, so a full buffer frees a slot exactly when out_ready pops it.
    assign space     = !sk_valid || out_ready;
    assign in_ready  = ((busy || any) && space) ? (N'(1) << cur_chan) : '0;
    assign push      = |(in_valid & in_ready);
    assign push_data = chan_data[cur_chan];
    assign push_last = in_last[cur_chan];
    assign drain     = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            lock      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            sk_valid  <= 1'b0;
            sk_data   <= '0;
            sk_last   <= 1'b0;
        end else begin
            if (push && push_last) begin
                state  <= IDLE;
                rr_ptr <= nxt;
            end else if (push && state == IDLE) begin
                state <= LOCKED;
                lock  <= grant;
            end
            if (push) begin
                sk_data <= push_data;
                sk_last <= push_last;
            end
            if (drain) begin
                out_valid <= sk_valid || push;
                sk_valid  <= sk_valid && push;
                if (sk_valid || push) begin
                    out_data <= sk_valid ? sk_data : push_data;
                    out_last <= sk_valid ? sk_last : push_last;
                end
            end else if (push) begin
                sk_valid <= 1'b1;
            end
        end
    end
endmodule
